lsu: RTL and testbench
======================

# lsu

Load/store unit for the RV32I pipeline's memory stage, directly downstream of the execute-stage ALU. It takes the ALU result as the effective address and rs2 as store data, and runs a request/response handshake with data memory. It steers and masks store bytes, then extracts and sign/zero-extends load data for writeback. It holds the pipeline with `o_busy` while an access is outstanding.

## Interface
- No parameters (RV32I, 32-bit data/address fixed).
- `i_clk` in 1: clock; single clock domain.
- `i_rst` in 1: synchronous, active-high reset.
- `i_valid` in 1: execute stage presents an instruction this cycle.
- `i_load` in 1: instruction is a load; ignored unless `i_valid`.
- `i_store` in 1: instruction is a store; ignored unless `i_valid`. `i_load & i_store` never both set.
- `i_funct3` in 3: access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `i_addr` in 32: effective address (ALU result).
- `i_wdata` in 32: store data (rs2).
- `i_rd` in 5: load destination register.
- `o_busy` out 1: stall upstream; upstream holds all inputs stable while high.
- `o_dmem_req` out 1: memory request valid.
- `o_dmem_addr` out 32: word-aligned address `{addr[31:2],2'b00}`.
- `o_dmem_wen` out 1: request is a write.
- `o_dmem_mask` out 4: byte enables.
- `o_dmem_wdata` out 32: lane-steered store data.
- `i_dmem_ready` in 1: memory accepts request this cycle.
- `i_dmem_rvalid` in 1: read data valid.
- `i_dmem_rdata` in 32: read word.
- `o_wb_valid` out 1: one-cycle pulse, load result valid.
- `o_wb_rd` out 5: load destination.
- `o_wb_data` out 32: extended load data.
- `o_fault` out 1: one-cycle pulse, access rejected (illegal funct3 or misaligned).

## Operation
- States: IDLE, REQ, WAIT.
- IDLE: when `i_valid & (i_load | i_store)`, capture addr/wdata/funct3/rd/type.
  - Legal access: go to REQ.
  - Illegal funct3 (011, 110, 111, or store with 1xx): no memory request; pulse `o_fault` next cycle; stay IDLE.
- REQ: `o_dmem_req`=1, outputs driven from captured registers and held constant until `i_dmem_ready`.
  - On ready with a store: go to IDLE.
  - On ready with a load: go to WAIT.
- WAIT: on `i_dmem_rvalid`, register the extended data, pulse `o_wb_valid` with `o_wb_rd` next cycle, go to IDLE. `i_dmem_rvalid` outside WAIT is ignored.
- Masks and lanes, with `o = addr[1:0]`:
  - B: mask `4'b0001<<o`, wdata byte replicated ×4.
  - H: mask `4'b0011<<o`, half replicated ×2.
  - W: mask `4'b1111`.
- Load extraction: select byte `rdata[8*o+:8]` or half `rdata[16*o[1]+:16]`. B/H sign-extend from the top bit; BU/HU zero-extend.
- `o_busy` = state != IDLE (registered). Accept is allowed only in IDLE.
- `i_rst` in any state forces IDLE and drops any outstanding request or response. A late `i_dmem_rvalid` after reset is ignored.

## Timing
- Reset values: all outputs 0; state IDLE.
- Accept at cycle N.
  - `o_dmem_req` and `o_busy` are high from N+1.
  - Store with ready at N+1: `o_busy` low at N+2. Store latency is 2 cycles minimum.
  - Load with ready at N+1 and rvalid at N+2: `o_wb_valid` at N+3, `o_busy` low at N+3. Load latency is 3 cycles minimum.
- Memory never asserts `i_dmem_rvalid` in the same cycle as `i_dmem_ready` for that request.
- `o_fault` and `o_wb_valid` are never high together.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - H with `addr[0]`=1, or W with `addr[1:0]`≠0, is rejected like an illegal funct3 (`o_fault` pulse, no request).
- Undefined:
  - No alignment check; offending low address bits are forced to zero for H (`addr[0]`) and W (`addr[1:0]`) before masking and extraction.
  - `o_fault` is driven only by illegal funct3.

## Structure
- `lsu_pkg`: state enum (IDLE/REQ/WAIT) and funct3 localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
- Sub-module `lsu_align`: combinational store steering (mask, wdata) and load extraction. Instantiated once; the FSM lives in `lsu`.

## Test plan
- SB: addr 0x1003, wdata 0x000000AB, ready at N+1 → mask 4'b1000, dmem_wdata 0xABABABAB, dmem_addr 0x1000, `o_busy` low at N+2.
- LB: addr 0x2002, rdata 0x12F45678 → wb_data 0xFFFFFFF4. LBU on the same access → 0x000000F4.
- LH: addr 0x2002, rdata 0x80010000, ready delayed 3 cycles, rvalid 2 cycles later → req/addr held stable throughout, wb_data 0xFFFF8001, `o_wb_valid` exactly one cycle.
- LW: addr 0x3002.
  - With `LSU_MISALIGN_TRAP_EN` → `o_fault` pulse, `o_dmem_req` never high.
  - Without it → dmem_addr 0x3000, mask 4'b1111.
- Illegal funct3 011 load → `o_fault` one cycle later, no request, `o_busy` stays low.
- `i_rst` asserted in WAIT, then rvalid next cycle → all outputs 0, no `o_wb_valid`, new access accepted normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the RV32I load/store unit: FSM states and funct3 size/sign codes.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering for stores and lane extraction plus extension for loads.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  mask,
  output logic [31:0] lane,
  output logic [31:0] ldata
);

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{off, 3'b000} +: 8];
  assign half_sel = rdata[{off[1], 4'b0000} +: 16];

  always_comb begin
    mask = 4'b1111;
    lane = wdata;
    case (funct3[1:0])
      2'b00: begin
        mask = 4'b0001 << off;
        lane = {4{wdata[7:0]}};
      end
      2'b01: begin
        mask = 4'b0011 << off;
        lane = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ldata = rdata;
    case (funct3)
      F3_B:    ldata = ext_byte(byte_sel, 1'b1);
      F3_BU:   ldata = ext_byte(byte_sel, 1'b0);
      F3_H:    ldata = ext_half(half_sel, 1'b1);
      F3_HU:   ldata = ext_half(half_sel, 1'b0);
      default: ldata = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// RV32I memory-stage load/store unit: IDLE/REQ/WAIT handshake with data memory.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned H/W accesses instead of truncating the address.
module lsu
  import lsu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_load,
  input  logic        i_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_rd,
  output logic        o_busy,
  output logic        o_dmem_req,
  output logic [31:0] o_dmem_addr,
  output logic        o_dmem_wen,
  output logic [3:0]  o_dmem_mask,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_ready,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_wb_valid,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  output logic        o_fault
);

  state_t      state, state_nx;
  logic [31:0] addr_p0, wdata_p0;
  logic [2:0]  f3_p0;
  logic [4:0]  rd_p0;
  logic        load_p0;
  logic        wb_vld_p1, fault_p1;
  logic [31:0] wb_data_p1;

  logic        accept, f3_bad, misalign, reject, resp;
  logic [1:0]  off;
  logic [3:0]  mask;
  logic [31:0] lane, ldata;

  assign accept = (state == IDLE) && i_valid && (i_load || i_store);
  assign resp   = (state == WAIT) && i_dmem_rvalid;

  always_comb begin
    f3_bad = 1'b1;
    case (i_funct3)
      F3_B, F3_H, F3_W: f3_bad = 1'b0;
      F3_BU, F3_HU:     f3_bad = i_store;
      default:          f3_bad = 1'b1;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((i_funct3 == F3_H || i_funct3 == F3_HU) && i_addr[0]) ||
                    ((i_funct3 == F3_W) && (i_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign reject = f3_bad || misalign;

  // Halfwords ignore addr[0] and words ignore addr[1:0]; only unreachable when trapping.
  always_comb begin
    off = addr_p0[1:0];
    case (f3_p0[1:0])
      2'b01:   off = {addr_p0[1], 1'b0};
      2'b10:   off = 2'b00;
      default: off = addr_p0[1:0];
    endcase
  end

  lsu_align u_align (
    .funct3 (f3_p0),
    .off    (off),
    .wdata  (wdata_p0),
    .rdata  (i_dmem_rdata),
    .mask   (mask),
    .lane   (lane),
    .ldata  (ldata)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && !reject) state_nx = REQ;
      REQ:     if (i_dmem_ready) state_nx = load_p0 ? WAIT : IDLE;
      WAIT:    if (i_dmem_rvalid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      wb_vld_p1  <= 1'b0;
      fault_p1   <= 1'b0;
      wb_data_p1 <= '0;
    end else begin
      state     <= state_nx;
      wb_vld_p1 <= resp;
      fault_p1  <= accept && reject;
      if (resp) wb_data_p1 <= ldata;
    end
  end

  // Capture stage: request fields held here for the whole REQ/WAIT window
  always_ff @(posedge i_clk) begin
    if (accept) begin
      addr_p0  <= i_addr;
      wdata_p0 <= i_wdata;
      f3_p0    <= i_funct3;
      rd_p0    <= i_rd;
      load_p0  <= i_load;
    end
  end

  assign o_busy       = (state != IDLE);
  assign o_dmem_req   = (state == REQ);
  assign o_dmem_addr  = o_dmem_req ? {addr_p0[31:2], 2'b00} : 32'h0;
  assign o_dmem_wen   = o_dmem_req && !load_p0;
  assign o_dmem_mask  = o_dmem_req ? mask : 4'h0;
  assign o_dmem_wdata = o_dmem_req ? lane : 32'h0;
  assign o_wb_valid   = wb_vld_p1;
  assign o_wb_rd      = wb_vld_p1 ? rd_p0 : 5'd0;
  assign o_wb_data    = wb_data_p1;
  assign o_fault      = fault_p1;

endmodule

// File: tb/tb_lsu.sv
// Table-driven bench for lsu with a scoreboard queue checked by a negedge monitor.
module tb_lsu;
  logic        clk = 1'b0;
  logic        rst, valid, load, store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [4:0]  rd;
  logic        busy, dmem_req, dmem_wen, dmem_ready, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_mask;
  logic        wb_valid, fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  lsu dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_load(load), .i_store(store),
    .i_funct3(funct3), .i_addr(addr), .i_wdata(wdata), .i_rd(rd),
    .o_busy(busy), .o_dmem_req(dmem_req), .o_dmem_addr(dmem_addr),
    .o_dmem_wen(dmem_wen), .o_dmem_mask(dmem_mask), .o_dmem_wdata(dmem_wdata),
    .i_dmem_ready(dmem_ready), .i_dmem_rvalid(dmem_rvalid), .i_dmem_rdata(dmem_rdata),
    .o_wb_valid(wb_valid), .o_wb_rd(wb_rd), .o_wb_data(wb_data), .o_fault(fault)
  );

  typedef struct {
    logic        ld;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic [31:0] e_addr;
    logic [3:0]  e_mask;
    logic [31:0] e_wdata;
    logic [31:0] e_wb;
    logic        e_fault;
  } vec_t;

  vec_t tbl[14];
  vec_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: DUT event with empty scoreboard at %0t", name, $time);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (dmem_req) begin
        if (sb.size() == 0) unexpected("req");
        else begin
          chk("req_expected", {31'd0, sb[0].e_fault}, 32'd0);
          chk("req_addr", dmem_addr, sb[0].e_addr);
          chk("req_mask", {28'd0, dmem_mask}, {28'd0, sb[0].e_mask});
          chk("req_wen", {31'd0, dmem_wen}, {31'd0, ~sb[0].ld});
          if (!sb[0].ld) chk("req_wdata", dmem_wdata, sb[0].e_wdata);
          if (dmem_ready && !sb[0].ld) void'(sb.pop_front());
        end
      end
      if (wb_valid) begin
        if (sb.size() == 0) unexpected("wb");
        else begin
          chk("wb_is_load", {31'd0, sb[0].ld}, 32'd1);
          chk("wb_data", wb_data, sb[0].e_wb);
          chk("wb_rd", {27'd0, wb_rd}, {27'd0, sb[0].rd});
          void'(sb.pop_front());
        end
      end
      if (fault) begin
        if (sb.size() == 0) unexpected("fault");
        else begin
          chk("fault_expected", {31'd0, sb[0].e_fault}, 32'd1);
          chk("fault_wb_excl", {31'd0, wb_valid}, 32'd0);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    valid = 1'b1; load = v.ld; store = ~v.ld;
    funct3 = v.f3; addr = v.addr; wdata = v.wdata; rd = v.rd;
    sb.push_back(v);
    tick();
    valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int rdy_dly, input int rv_dly);
    int guard;
    drive(v);
    if (v.e_fault) begin
      chk("fault_busy", {31'd0, busy}, 32'd0);
      chk("fault_pulse", {31'd0, fault}, 32'd1);
      tick();
      chk("fault_clear", {31'd0, fault}, 32'd0);
    end else begin
      repeat (rdy_dly) tick();
      dmem_ready = 1'b1;
      tick();
      dmem_ready = 1'b0;
      if (v.ld) begin
        repeat (rv_dly) tick();
        dmem_rvalid = 1'b1;
        dmem_rdata = v.rdata;
        tick();
        dmem_rvalid = 1'b0;
        dmem_rdata = 32'h0;
        chk("ld_wb_pulse", {31'd0, wb_valid}, 32'd1);
        chk("ld_busy_low", {31'd0, busy}, 32'd0);
        tick();
        chk("ld_wb_one_cycle", {31'd0, wb_valid}, 32'd0);
      end else begin
        chk("st_busy_low", {31'd0, busy}, 32'd0);
      end
    end
    guard = 0;
    while ((sb.size() != 0 || busy) && guard < 20) begin
      tick();
      guard++;
    end
    chk("drain_timeout", guard, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b0, 3'b000, 32'h1003, 32'h000000AB, 32'h0, 5'd0, 32'h1000, 4'b1000, 32'hABABABAB, 32'h0, 1'b0};
    tbl[1]  = '{1'b0, 3'b001, 32'h1002, 32'h1234CDEF, 32'h0, 5'd0, 32'h1000, 4'b1100, 32'hCDEFCDEF, 32'h0, 1'b0};
    tbl[2]  = '{1'b0, 3'b010, 32'h1004, 32'hDEADBEEF, 32'h0, 5'd0, 32'h1004, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0};
    tbl[3]  = '{1'b1, 3'b000, 32'h2002, 32'h0, 32'h12F45678, 5'd3, 32'h2000, 4'b0100, 32'h0, 32'hFFFFFFF4, 1'b0};
    tbl[4]  = '{1'b1, 3'b100, 32'h2002, 32'h0, 32'h12F45678, 5'd4, 32'h2000, 4'b0100, 32'h0, 32'h000000F4, 1'b0};
    tbl[5]  = '{1'b1, 3'b001, 32'h2002, 32'h0, 32'h80010000, 5'd5, 32'h2000, 4'b1100, 32'h0, 32'hFFFF8001, 1'b0};
    tbl[6]  = '{1'b1, 3'b101, 32'h2000, 32'h0, 32'h7FFF8001, 5'd6, 32'h2000, 4'b0011, 32'h0, 32'h00008001, 1'b0};
    tbl[7]  = '{1'b1, 3'b010, 32'h3000, 32'h0, 32'hCAFEF00D, 5'd7, 32'h3000, 4'b1111, 32'h0, 32'hCAFEF00D, 1'b0};
    tbl[8]  = '{1'b1, 3'b000, 32'h2001, 32'h0, 32'h12F45678, 5'd8, 32'h2000, 4'b0010, 32'h0, 32'h00000056, 1'b0};
    tbl[9]  = '{1'b1, 3'b011, 32'h4000, 32'h0, 32'h0, 5'd9, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1};
    tbl[10] = '{1'b0, 3'b100, 32'h4001, 32'h55, 32'h0, 5'd0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1};
    tbl[11] = '{1'b1, 3'b111, 32'h4000, 32'h0, 32'h0, 5'd11, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1};
`ifdef LSU_MISALIGN_TRAP_EN
    tbl[12] = '{1'b1, 3'b010, 32'h3002, 32'h0, 32'h11223344, 5'd12, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1};
    tbl[13] = '{1'b1, 3'b001, 32'h2003, 32'h0, 32'hABCD0000, 5'd13, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1};
`else
    tbl[12] = '{1'b1, 3'b010, 32'h3002, 32'h0, 32'h11223344, 5'd12, 32'h3000, 4'b1111, 32'h0, 32'h11223344, 1'b0};
    tbl[13] = '{1'b1, 3'b001, 32'h2003, 32'h0, 32'hABCD0000, 5'd13, 32'h2000, 4'b1100, 32'h0, 32'hFFFFABCD, 1'b0};
`endif

    rst = 1'b1; valid = 1'b0; load = 1'b0; store = 1'b0; funct3 = 3'b000;
    addr = 32'h0; wdata = 32'h0; rd = 5'd0;
    dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    repeat (3) tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 14; i++) run_vec(tbl[i], 0, 0);

    // LH with ready held off 3 cycles and rvalid 2 cycles later
    run_vec(tbl[5], 3, 2);

    // stray rvalid while idle
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADDEAD;
    tick();
    dmem_rvalid = 1'b0;
    chk("stray_rvalid_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("stray_rvalid_wb", {31'd0, wb_valid}, 32'd0);

    // reset while waiting for read data, then a late rvalid
    drive(tbl[7]);
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    chk("wait_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h87654321;
    chk("rstw_busy", {31'd0, busy}, 32'd0);
    chk("rstw_req", {31'd0, dmem_req}, 32'd0);
    chk("rstw_addr", dmem_addr, 32'd0);
    chk("rstw_mask", {28'd0, dmem_mask}, 32'd0);
    chk("rstw_wdata", dmem_wdata, 32'd0);
    chk("rstw_wen", {31'd0, dmem_wen}, 32'd0);
    chk("rstw_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rstw_wb_data", wb_data, 32'd0);
    chk("rstw_fault", {31'd0, fault}, 32'd0);
    tick();
    dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    chk("rstw_late_rvalid", {31'd0, wb_valid}, 32'd0);
    tick();
    run_vec(tbl[3], 0, 0);
    run_vec(tbl[0], 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
